// File: rtl/seg7_pkg.sv
// Shared constants, hex glyph table and scan state type for the 4-digit 7-segment scanner.
package seg7_pkg;
  localparam int              NUM_DIGITS = 4;
  localparam logic [6:0]      SEG_OFF    = 7'b0000000;
  localparam logic [NUM_DIGITS-1:0] LINE_OFF = '1;

  // Segment order {a,b,c,d,e,f,g}, 1 = lit; entry 15 first so index == nibble.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  typedef enum logic {BLANK, SHOW} scan_state_t;
endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to 7-segment glyph lookup.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-segment scan controller with double-buffered value and frame-aligned commit.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero suppression on digits 3..1.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  line,
  output logic        frame_start
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t               state, state_nxt;
  logic [CW-1:0]             cnt, cnt_nxt;
  logic [IW-1:0]             idx, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0] shadow, active;
  logic [NUM_DIGITS-1:0]     shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0][6:0] dec_seg, digit_seg;
  logic [6:0]                seg_nxt;
  logic                      dp_nxt, frame_nxt, xfer, commit;
  logic [NUM_DIGITS-1:0]     line_nxt;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    seg7_hex_decoder u_dec (.nibble(active[k]), .seg(dec_seg[k]));
`ifdef SEG7_LZ_BLANK_EN
    if (k == 0) begin : g_lsd
      assign digit_seg[k] = dec_seg[k];
    end else begin : g_lz
      // Blank only when this digit and every higher digit are zero.
      assign digit_seg[k] = (~|active[NUM_DIGITS-1:k]) ? SEG_OFF : dec_seg[k];
    end
`else
    assign digit_seg[k] = dec_seg[k];
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;
    line_nxt  = LINE_OFF;
    frame_nxt = 1'b0;
    if (!enable) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      frame_nxt = (cnt == '0) && (idx == '0);
      case (state)
        BLANK: if (cnt == BLANK_LAST) state_nxt = SHOW;
        SHOW: begin
          line_nxt[idx] = 1'b0;
          seg_nxt       = digit_seg[idx];
          dp_nxt        = ~active_dp[idx];
        end
        default: state_nxt = BLANK;
      endcase
      if (cnt == CNT_LAST) begin
        cnt_nxt   = '0;
        idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        state_nxt = BLANK;
      end
    end
  end

  // A write landing on the commit cycle sees wr_ready=1, so nothing is pending to commit yet.
  assign xfer   = wr_valid & wr_ready;
  assign commit = frame_nxt & ~wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      shadow_dp   <= '0;
      active      <= '0;
      active_dp   <= '0;
      wr_ready    <= 1'b1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      line        <= LINE_OFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      line        <= line_nxt;
      frame_start <= frame_nxt;
      if (commit) begin
        active    <= shadow;
        active_dp <= shadow_dp;
        wr_ready  <= 1'b1;
      end
      if (xfer) begin
        shadow    <= wr_data;
        shadow_dp <= wr_dp;
        wr_ready  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (SLOT_CYCLES=8, BLANK_CYCLES=2); honours SEG7_LZ_BLANK_EN.
// Frame-position model checked every cycle, plus directed literal checks.
module tb_seg7_scan_ctrl;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;
  localparam logic [11:0] DARK = {7'b0, 1'b1, 4'hF};
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  localparam logic [6:0] SCAN_SEG  [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
  localparam logic [3:0] SCAN_LINE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] ZERO_HI = 7'b0000000;
`else
  localparam logic [6:0] ZERO_HI = 7'b1111110;
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable, wr_valid, wr_ready, dp, frame_start;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp, line;
  logic [6:0]  seg;

  int vectors = 0;
  int miscompares = 0;
  int offset = 0;

  seg7_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dp(wr_dp), .seg(seg), .dp(dp), .line(line), .frame_start(frame_start));

  always #5 clk = ~clk;

  // Model: position within the frame counted in enabled clocks since scanning (re)started.
  int          m_pos;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_act_dp, m_sh_dp;
  logic        m_ready, e_fs;
  logic [11:0] e_disp;

  function automatic logic [11:0] expect_disp(input int pos, input logic [15:0] act,
                                              input logic [3:0] adp);
    int slot;
    logic [3:0] nib;
    logic [6:0] g;
    slot = (pos / SLOT) % 4;
    if ((pos % SLOT) < BLANK) return DARK;
    nib = 4'(act >> (4 * slot));
    g   = GLYPH[nib];
`ifdef SEG7_LZ_BLANK_EN
    if (slot > 0 && (act >> (4 * slot)) == 16'h0) g = 7'b0;
`endif
    return {g, ~adp[slot], ~(4'b0001 << slot)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0; m_act <= '0; m_sh <= '0; m_act_dp <= '0; m_sh_dp <= '0;
      m_ready <= 1'b1; e_fs <= 1'b0; e_disp <= DARK;
    end else begin
      if (enable) begin
        e_disp <= expect_disp(m_pos, m_act, m_act_dp);
        e_fs   <= (m_pos == 0);
        m_pos  <= (m_pos + 1) % FRAME;
        if (m_pos == 0 && !m_ready) begin
          m_act <= m_sh; m_act_dp <= m_sh_dp; m_ready <= 1'b1;
        end
      end else begin
        e_disp <= DARK; e_fs <= 1'b0; m_pos <= 0;
      end
      if (wr_valid && m_ready) begin
        m_sh <= wr_data; m_sh_dp <= wr_dp; m_ready <= 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    vectors++;
    if ({seg, dp, line, frame_start, wr_ready} !== {e_disp, e_fs, m_ready}) begin
      miscompares++;
      $display("FAIL cycle t=%0t: got seg=%b dp=%b line=%b fs=%b rdy=%b, want seg=%b dp=%b line=%b fs=%b rdy=%b",
               $time, seg, dp, line, frame_start, wr_ready,
               e_disp[11:5], e_disp[4], e_disp[3:0], e_fs, m_ready);
    end
  end

  task automatic chk7(input string name, input logic [6:0] a, input logic [6:0] e);
    vectors++;
    if (a !== e) begin miscompares++; $display("FAIL %s: got %b want %b", name, a, e); end
  endtask
  task automatic chk4(input string name, input logic [3:0] a, input logic [3:0] e);
    vectors++;
    if (a !== e) begin miscompares++; $display("FAIL %s: got %b want %b", name, a, e); end
  endtask
  task automatic chk1(input string name, input logic a, input logic e);
    vectors++;
    if (a !== e) begin miscompares++; $display("FAIL %s: got %b want %b", name, a, e); end
  endtask

  task automatic sync_frame();
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 40);
    if (frame_start !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL sync_frame: no frame_start within 40 cycles");
    end
    offset = 0;
  endtask

  task automatic step_to(input int o);
    while (offset < o) begin @(negedge clk); offset++; end
  endtask

  task automatic check_dark(input string name);
    chk4({name, "_line"}, line, 4'hF);
    chk7({name, "_seg"}, seg, 7'b0);
    chk1({name, "_dp"}, dp, 1'b1);
    chk1({name, "_fs"}, frame_start, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_dp = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_dark("reset");
    chk1("reset_ready", wr_ready, 1'b1);
    rst_n = 1'b1;

    // Load 1234 while dark, then start scanning.
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 16'h1234; wr_dp = 4'b0000;
    @(negedge clk);
    wr_valid = 1'b0;
    chk1("idle_write_ready", wr_ready, 1'b0);
    enable = 1'b1;
    sync_frame();
    chk1("first_commit_ready", wr_ready, 1'b1);
    for (int o = 1; o < FRAME; o++) begin
      step_to(o);
      if (o % SLOT < BLANK) begin
        chk4("scan_gap_line", line, 4'hF);
        chk7("scan_gap_seg", seg, 7'b0);
      end else begin
        chk4("scan_line", line, SCAN_LINE[o / SLOT]);
        chk7("scan_seg", seg, SCAN_SEG[o / SLOT]);
      end
    end

    // Mid-frame write, then a second offer that must be held off.
    sync_frame();
    step_to(12);
    wr_valid = 1'b1; wr_data = 16'hABCD; wr_dp = 4'b0001;
    step_to(13);
    chk1("hs_ready_drop", wr_ready, 1'b0);
    wr_data = 16'h9999; wr_dp = 4'b1111;
    step_to(20);
    chk1("hs_held_off", wr_ready, 1'b0);
    wr_valid = 1'b0;
    step_to(26);
    chk7("hs_old_digit3", seg, 7'b0110000);
    sync_frame();
    chk1("hs_ready_back", wr_ready, 1'b1);
    step_to(2);
    chk7("hs_d_seg", seg, 7'b0111101);
    chk1("hs_d_dp", dp, 1'b0);
    chk4("hs_d_line", line, 4'b1110);
    step_to(10);
    chk7("hs_C_seg", seg, 7'b1001110);
    chk1("hs_C_dp", dp, 1'b1);

    // Write on the frame_start cycle: appears one frame later.
    sync_frame();
    wr_valid = 1'b1; wr_data = 16'h0005; wr_dp = 4'b0000;
    step_to(1);
    wr_valid = 1'b0;
    chk1("simul_ready", wr_ready, 1'b0);
    step_to(2);
    chk7("simul_still_d", seg, 7'b0111101);
    sync_frame();
    chk1("simul_ready_back", wr_ready, 1'b1);
    step_to(2);
    chk7("simul_5_seg", seg, 7'b1011011);
    chk1("simul_5_dp", dp, 1'b1);
    step_to(26);
    chk7("simul_digit3", seg, ZERO_HI);
    chk4("simul_digit3_line", line, 4'b0111);

    // Leading zeros.
    step_to(28);
    wr_valid = 1'b1; wr_data = 16'h0042;
    step_to(29);
    wr_valid = 1'b0;
    sync_frame();
    step_to(2);  chk7("lz_digit0", seg, 7'b1101101);
    step_to(10); chk7("lz_digit1", seg, 7'b0110011);
    step_to(18); chk7("lz_digit2", seg, ZERO_HI); chk4("lz_digit2_line", line, 4'b1011);
    step_to(26); chk7("lz_digit3", seg, ZERO_HI); chk4("lz_digit3_line", line, 4'b0111);

    // Disable mid-SHOW, then resume.
    sync_frame();
    step_to(4);
    enable = 1'b0;
    step_to(5);
    check_dark("disable");
    step_to(8);
    enable = 1'b1;
    step_to(9);
    chk1("reenable_fs", frame_start, 1'b1);
    step_to(11);
    chk4("reenable_line", line, 4'b1110);
    chk7("reenable_seg", seg, 7'b1101101);

    // Asynchronous reset mid-frame drops the pending value.
    step_to(12);
    wr_valid = 1'b1; wr_data = 16'h7777;
    step_to(13);
    wr_valid = 1'b0;
    chk1("pre_reset_ready", wr_ready, 1'b0);
    step_to(14);
    #2 rst_n = 1'b0;
    #1;
    check_dark("async_reset");
    chk1("async_reset_ready", wr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    sync_frame();
    step_to(2);
    chk7("post_reset_digit0", seg, 7'b1111110);
    chk4("post_reset_line", line, 4'b1110);
    step_to(26);
    chk7("post_reset_digit3", seg, ZERO_HI);
    step_to(31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
